// File: rtl/line_rdout_pack_if.sv
// =============================================================================
// line_rdout_pack_if
// Line-RAM read port, DMA FIFO write port and status bundle for line_rdout_pack.
// Revision: 1.0
// =============================================================================
`default_nettype none

interface line_rdout_pack_if;
    logic        bank_a_we;
    logic        bank_b_we;
    logic [12:0] hori_pix_num;
    logic        rd_en;
    logic        rd_bank;
    logic [14:0] rd_addr;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [31:0] fifo_din;
    logic        fifo_wr;
    logic        fifo_afull;
    logic        busy;
    logic [15:0] line_cnt;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    modport master (
        input  bank_a_we, bank_b_we, hori_pix_num, rd_data_a, rd_data_b, fifo_afull,
        output rd_en, rd_bank, rd_addr, fifo_din, fifo_wr, busy, line_cnt,
        output overrun, overrun_cnt
    );

    modport slave (
        output bank_a_we, bank_b_we, hori_pix_num, rd_data_a, rd_data_b, fifo_afull,
        input  rd_en, rd_bank, rd_addr, fifo_din, fifo_wr, busy, line_cnt,
        input  overrun, overrun_cnt
    );
endinterface

`default_nettype wire

// File: rtl/line_rdout_pack.sv
// =============================================================================
// line_rdout_pack
// Drains completed ping-pong line banks, packs 16-bit pixels into 32-bit words
// and pushes a header plus payload into the DMA FIFO.
// Revision: 1.0
// =============================================================================
`default_nettype none

module line_rdout_pack #(
    parameter int unsigned RD_LAT  = 1,
    parameter logic [7:0]  HDR_TAG = 8'hA5
) (
    input wire clk,
    input wire rst_n,
    line_rdout_pack_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        we_a_q, we_b_q;
    logic        pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic        bank_q, bank_d;
    logic [14:0] len_q, len_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        ovr_q;
    logic [7:0]  ovr_cnt_q;
    logic [2:0]  pipe_q [RD_LAT];
    logic [15:0] lo_q;
    logic        wr_q;
    logic [31:0] din_q;

    logic        fall_a, fall_b, act_a, act_b, ovr_a, ovr_b;
    logic        hdr_wr, rd_go, last_addr, pipe_busy;
    logic        v_out, odd_out, last_out;
    logic [14:0] len3;
    logic [15:0] rdata;
    logic [8:0]  ovr_sum;

    assign fall_a = we_a_q & ~bus.bank_a_we;
    assign fall_b = we_b_q & ~bus.bank_b_we;
    // A bank is "owned" while pending or while its line is in flight.
    assign act_a  = pend_a_q | ((state_q != S_IDLE) & ~bank_q);
    assign act_b  = pend_b_q | ((state_q != S_IDLE) &  bank_q);
    assign ovr_a  = fall_a & act_a;
    assign ovr_b  = fall_b & act_b;

    assign len3      = {1'b0, bus.hori_pix_num, 1'b0} + {2'b00, bus.hori_pix_num};
    assign hdr_wr    = (state_q == S_HDR) & ~bus.fifo_afull;
    assign rd_go     = (state_q == S_READ) & ~bus.fifo_afull;
    assign last_addr = (addr_q == len_q - 15'd1);
    assign {v_out, odd_out, last_out} = pipe_q[RD_LAT-1];
    assign rdata     = bank_q ? bus.rd_data_b : bus.rd_data_a;
    assign ovr_sum   = {1'b0, ovr_cnt_q} + {8'd0, ovr_a} + {8'd0, ovr_b};

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_busy = pipe_busy | pipe_q[i][2];
        end
    end

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        len_d      = len_q;
        addr_d     = addr_q;
        line_cnt_d = line_cnt_q;
        pend_a_d   = pend_a_q | (fall_a & ~act_a);
        pend_b_d   = pend_b_q | (fall_b & ~act_b);
        case (state_q)
            S_IDLE: begin
                if (pend_a_q | pend_b_q) begin
                    state_d = S_HDR;
                    bank_d  = ~pend_a_q;
                    len_d   = len3;
                    if (pend_a_q) pend_a_d = 1'b0;
                    else          pend_b_d = 1'b0;
                end
            end
            S_HDR: begin
                if (!bus.fifo_afull) begin
                    addr_d  = 15'd0;
                    state_d = (len_q == 15'd0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (!bus.fifo_afull) begin
                    addr_d = addr_q + 15'd1;
                    if (last_addr) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pipe_busy && !wr_q) state_d = S_DONE;
            end
            S_DONE: begin
                line_cnt_d = line_cnt_q + 16'd1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_a_q     <= 1'b0;
            we_b_q     <= 1'b0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            bank_q     <= 1'b0;
            len_q      <= 15'd0;
            addr_q     <= 15'd0;
            line_cnt_q <= 16'd0;
            ovr_q      <= 1'b0;
            ovr_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            we_a_q     <= bus.bank_a_we;
            we_b_q     <= bus.bank_b_we;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            bank_q     <= bank_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            line_cnt_q <= line_cnt_d;
            ovr_q      <= ovr_a | ovr_b;
            ovr_cnt_q  <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
        end
    end

    // Read pipeline tags each issued read with {valid, odd address, last pixel}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) pipe_q[i] <= 3'b000;
            lo_q  <= 16'd0;
            wr_q  <= 1'b0;
            din_q <= 32'd0;
        end else begin
            pipe_q[0] <= {rd_go, addr_q[0], last_addr};
            for (int i = 1; i < int'(RD_LAT); i++) pipe_q[i] <= pipe_q[i-1];
            wr_q <= v_out & (odd_out | last_out);
            if (v_out) begin
                if (odd_out) begin
                    din_q <= {rdata, lo_q};
                end else begin
                    lo_q <= rdata;
                    if (last_out) din_q <= {16'h0000, rdata};
                end
            end
        end
    end

    assign bus.rd_en       = rd_go;
    assign bus.rd_bank     = bank_q;
    assign bus.rd_addr     = addr_q;
    assign bus.fifo_wr     = hdr_wr | wr_q;
    assign bus.fifo_din    = hdr_wr ? {HDR_TAG, bank_q, 7'd0, line_cnt_q} : din_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.line_cnt    = line_cnt_q;
    assign bus.overrun     = ovr_q;
    assign bus.overrun_cnt = ovr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_line_rdout_pack.sv
// =============================================================================
// tb_line_rdout_pack
// Directed self-checking bench for line_rdout_pack.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_line_rdout_pack;

    logic clk;
    logic rst_n;
    line_rdout_pack_if bus();

    line_rdout_pack #(.RD_LAT(1), .HDR_TAG(8'hA5)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram_a [0:63];
    logic [15:0] ram_b [0:63];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= ram_a[bus.rd_addr[5:0]];
            bus.rd_data_b <= ram_b[bus.rd_addr[5:0]];
        end
    end

    logic [31:0] cap_q [$];
    logic [31:0] exp_q [$];
    int n_rd, n_rd_full, n_rd_bank0, n_ovr;
    int n_checks, n_errors;

    always @(negedge clk) begin
        if (bus.fifo_wr) cap_q.push_back(bus.fifo_din);
        if (bus.rd_en) n_rd++;
        if (bus.rd_en && bus.fifo_afull) n_rd_full++;
        if (bus.rd_en && !bus.rd_bank) n_rd_bank0++;
        if (bus.overrun) n_ovr++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        cap_q.delete();
        exp_q.delete();
        n_rd = 0; n_rd_full = 0; n_rd_bank0 = 0; n_ovr = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.bank_a_we = 1'b0;
        bus.bank_b_we = 1'b0;
        bus.fifo_afull = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        clear_mon();
    endtask

    // Raise the bank's write window for one cycle, then drop it (falling edge).
    task automatic pulse_we(input logic b);
        @(posedge clk); #1;
        if (b) bus.bank_b_we = 1'b1; else bus.bank_a_we = 1'b1;
        @(posedge clk); #1;
        if (b) bus.bank_b_we = 1'b0; else bus.bank_a_we = 1'b0;
    endtask

    task automatic check_words(input string tag);
        check_val({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check_val($sformatf("%s_w%0d", tag, i),
                      (i < cap_q.size()) ? cap_q[i] : 32'hDEADDEAD, exp_q[i]);
        end
    endtask

    task automatic push_line_a4(input logic [15:0] lc);
        exp_q.push_back({16'hA500, lc});
        exp_q.push_back(32'h00010000); exp_q.push_back(32'h00030002);
        exp_q.push_back(32'h00050004); exp_q.push_back(32'h00070006);
        exp_q.push_back(32'h00090008); exp_q.push_back(32'h000B000A);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0;
        bus.bank_a_we = 1'b0; bus.bank_b_we = 1'b0;
        bus.fifo_afull = 1'b0; bus.hori_pix_num = 13'd4;
        bus.rd_data_a = 16'd0; bus.rd_data_b = 16'd0;
        for (int i = 0; i < 64; i++) begin
            ram_a[i] = 16'(i);
            ram_b[i] = 16'(16'h0100 + i);
        end
        clear_mon();
        cycles(2);
        check_val("rst_rd_en",   {31'd0, bus.rd_en},   32'd0);
        check_val("rst_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
        check_val("rst_busy",    {31'd0, bus.busy},    32'd0);
        check_val("rst_din",     bus.fifo_din,         32'd0);
        check_val("rst_addr",    {17'd0, bus.rd_addr}, 32'd0);
        check_val("rst_ovrcnt",  {24'd0, bus.overrun_cnt}, 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // N=4, bank A
        do_reset();
        bus.hori_pix_num = 13'd4;
        pulse_we(1'b0);
        cycles(2);
        check_val("t1_busy", {31'd0, bus.busy}, 32'd1);
        cycles(40);
        push_line_a4(16'h0000);
        check_words("t1");
        check_val("t1_line_cnt", {16'd0, bus.line_cnt}, 32'd1);
        check_val("t1_nrd", 32'(n_rd), 32'd12);

        // N=3, bank B
        do_reset();
        bus.hori_pix_num = 13'd3;
        pulse_we(1'b1);
        cycles(40);
        exp_q.push_back(32'hA5800000);
        exp_q.push_back(32'h01010100); exp_q.push_back(32'h01030102);
        exp_q.push_back(32'h01050104); exp_q.push_back(32'h01070106);
        exp_q.push_back(32'h00000108);
        check_words("t2");
        check_val("t2_bank0_reads", 32'(n_rd_bank0), 32'd0);
        check_val("t2_nrd", 32'(n_rd), 32'd9);

        // N=4 with a 10-cycle almost-full stall mid-READ
        do_reset();
        bus.hori_pix_num = 13'd4;
        pulse_we(1'b0);
        cycles(5);
        bus.fifo_afull = 1'b1;
        cycles(10);
        bus.fifo_afull = 1'b0;
        cycles(40);
        push_line_a4(16'h0000);
        check_words("t3");
        check_val("t3_rd_while_full", 32'(n_rd_full), 32'd0);
        check_val("t3_nrd", 32'(n_rd), 32'd12);

        // Ping-pong: A, then B three cycles later
        do_reset();
        bus.hori_pix_num = 13'd4;
        pulse_we(1'b0);
        cycles(1);
        pulse_we(1'b1);
        cycles(60);
        push_line_a4(16'h0000);
        exp_q.push_back(32'hA5800001);
        exp_q.push_back(32'h01010100); exp_q.push_back(32'h01030102);
        exp_q.push_back(32'h01050104); exp_q.push_back(32'h01070106);
        exp_q.push_back(32'h01090108); exp_q.push_back(32'h010B010A);
        check_words("t4");
        check_val("t4_ovr_pulses", 32'(n_ovr), 32'd0);
        check_val("t4_line_cnt", {16'd0, bus.line_cnt}, 32'd2);

        // Second A edge while A is being read
        do_reset();
        pulse_we(1'b0);
        cycles(4);
        pulse_we(1'b0);
        cycles(50);
        push_line_a4(16'h0000);
        check_words("t5");
        check_val("t5_ovr_pulses", 32'(n_ovr), 32'd1);
        check_val("t5_ovr_cnt", {24'd0, bus.overrun_cnt}, 32'd1);
        check_val("t5_line_cnt", {16'd0, bus.line_cnt}, 32'd1);

        // N=0: header only
        do_reset();
        bus.hori_pix_num = 13'd0;
        pulse_we(1'b0);
        cycles(20);
        exp_q.push_back(32'hA5000000);
        check_words("t6");
        check_val("t6_nrd", 32'(n_rd), 32'd0);

        // Reset mid-READ after one full line, then a fresh line
        do_reset();
        bus.hori_pix_num = 13'd4;
        pulse_we(1'b0);
        cycles(30);
        check_val("t7_line_cnt_pre", {16'd0, bus.line_cnt}, 32'd1);
        pulse_we(1'b0);
        cycles(6);
        rst_n = 1'b0;
        #1;
        check_val("t7_rst_busy",  {31'd0, bus.busy},    32'd0);
        check_val("t7_rst_rd_en", {31'd0, bus.rd_en},   32'd0);
        check_val("t7_rst_wr",    {31'd0, bus.fifo_wr}, 32'd0);
        check_val("t7_rst_addr",  {17'd0, bus.rd_addr}, 32'd0);
        check_val("t7_rst_lcnt",  {16'd0, bus.line_cnt}, 32'd0);
        check_val("t7_rst_din",   bus.fifo_din,         32'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        clear_mon();
        pulse_we(1'b0);
        cycles(40);
        push_line_a4(16'h0000);
        check_words("t7");
        check_val("t7_line_cnt", {16'd0, bus.line_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/line_rdout_pack.md
# line_rdout_pack

Drains completed scan lines from the ping-pong line RAM written by the ADC write stage, packs 16-bit pixels into 32-bit words and pushes a header plus the pixel payload into the PCIe DMA FIFO. It sits directly downstream of the line-buffer writer: bank A/B write enables mark line completion, and this block reads the finished bank in address order 0..3N-1. The writer already applies mirroring, so this block reads linearly.

## Interface
Parameters:
- RD_LAT, 1, RAM read latency in clk cycles (only 1 supported).
- HDR_TAG, 8'hA5, tag byte in header word [31:24].

Ports:
- clk  in  1  system clock; RAM and FIFO share it.
- rst_n  in  1  reset, asynchronous, active-low.
- bank_a_we  in  1  bank A write-window enable from writer; falling edge = line in A complete.
- bank_b_we  in  1  bank B write-window enable; falling edge = line in B complete.
- hori_pix_num  in  13  N; line length is 3N pixels; quasi-static.
- rd_en  out  1  RAM read strobe.
- rd_bank  out  1  0 = bank A, 1 = bank B.
- rd_addr  out  15  RAM read address.
- rd_data_a  in  16  bank A read data, valid RD_LAT cycles after rd_en.
- rd_data_b  in  16  bank B read data.
- fifo_din  out  32  word to DMA FIFO.
- fifo_wr  out  1  FIFO write strobe, one word per cycle.
- fifo_afull  in  1  FIFO almost-full; asserted with ≥4 free entries remaining.
- busy  out  1  high from HDR through DONE.
- line_cnt  out  16  lines emitted, wraps at 65535→0.
- overrun  out  1  one-cycle pulse on dropped line.
- overrun_cnt  out  8  dropped lines, saturates at 255.

## Operation
- Edge detect: we_a_d/we_b_d registers; a falling edge sets pending_a/pending_b.
- Overrun: a falling edge for bank X while X is pending or being read -> overrun pulse, overrun_cnt+1 (saturating), and the request is dropped (pending is not re-set).
- Arbitration in IDLE: serve the only pending bank; if both are pending, serve A. Clear pending for the chosen bank on entry to HDR.
- FSM states IDLE, HDR, READ, DRAIN, DONE.
  - IDLE -> HDR when any bank is pending; latch bank, and latch len = 3*N as a 15-bit product.
  - If N==0, go HDR -> DONE; the header is written with no payload.
  - HDR: when !fifo_afull, write the header {HDR_TAG, bank, 7'b0, line_cnt}, then go to READ with addr=0.
  - READ: each cycle with !fifo_afull, issue rd_en at addr and increment addr. After issuing addr len-1, go to DRAIN.
  - DRAIN: wait for the last read data, then emit any partial word. Go to DONE once the pipeline is empty.
  - DONE: line_cnt+1, then IDLE.
- Packing:
  - even-address pixel -> [15:0]; odd-address pixel -> [31:16]; a word is written after each odd pixel.
  - If len is odd, the final word is {16'h0000, last pixel}, written in DRAIN.
- Words per line: 1 + ceil(3N/2).
- Reset: all outputs 0 (rd_en, rd_bank, rd_addr, fifo_din, fifo_wr, busy, line_cnt, overrun, overrun_cnt); pending flags are cleared and the FSM returns to IDLE. A reset mid-line abandons the line with no padding.

## Timing
- Edge on bank_X_we sampled at cycle 0 -> pending at cycle 1 -> HDR at cycle 2.
  - Header fifo_wr at cycle 2 if !fifo_afull.
- Read pipeline: rd_en at t -> data sampled at t+1 -> fifo_wr for an odd pixel at t+2.
  - Unstalled throughput is 1 read per cycle and 1 FIFO word per 2 cycles.
- fifo_afull stalls only the issue of new reads and header writes. In-flight data (≤2 words) is always written.
- Unstalled line time from the edge to the return to IDLE ≈ 3N+6 cycles.
- The non-served bank may go pending during a line; it is served immediately after DONE.
- Simultaneous edges on A and B: both go pending, A is served first, no overrun.

## Test plan
- N=4, single falling edge on bank_a_we, RAM A[i]=i:
  - 7 words: header A5000000, then 00010000, 00030002, … 000B000A.
  - line_cnt=1.
- N=3, bank B, RAM B[i]=0x100+i:
  - header A5800000 plus 5 words; last word 00000108.
  - rd_bank=1 throughout.
- N=4 with fifo_afull held high 10 cycles mid-READ:
  - no rd_en while high; exactly 7 words total, no loss or duplicates.
- Ping-pong: A edge, then B edge 3 cycles later:
  - A line then B line back-to-back, headers with line_cnt 0 and 1.
  - overrun never pulses.
- Second A edge while A is being read:
  - overrun pulses 1 cycle, overrun_cnt=1, only one A line emitted.
- rst_n low mid-READ:
  - outputs 0 immediately; after release, a new A edge gives a full line with header line_cnt=0.
